// File: rtl/sprite_popup_ctl_if.sv
// Handshake and position bus between the game FSM and the sprite pop-up controller.
interface sprite_popup_ctl_if;
  localparam int unsigned POS_W = 12;

  logic             tick;
  logic             start;
  logic             abort;
  logic [POS_W-1:0] duck_xpos;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             busy;
  logic             done;

  modport master (output tick, start, abort, duck_xpos,
                  input  xpos, ypos, busy, done);
  modport slave  (input  tick, start, abort, duck_xpos,
                  output xpos, ypos, busy, done);
endinterface

// File: rtl/sprite_popup_ctl.sv
// Vertical pop-up motion controller: rise from a hidden row to a peak, hold, fall back.
// Optional macro SPRITE_XTRACK_EN: xpos follows duck_xpos every cycle while busy.
module sprite_popup_ctl #(
  parameter int unsigned FRAC_BITS  = 24,
  parameter int unsigned Y_HIDDEN   = 700,
  parameter int unsigned Y_PEAK     = 480,
  parameter int unsigned UP_STEP    = 1536,
  parameter int unsigned DOWN_STEP  = 1536,
  parameter int unsigned HOLD_TICKS = 60,
  parameter int unsigned X_DEFAULT  = 200
) (
  input logic          clk,
  input logic          rst_n,
  sprite_popup_ctl_if.slave bus
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned INT_W = POS_W + 1;
  localparam int unsigned ACC_W = POS_W + FRAC_BITS;
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

  localparam logic [ACC_W-1:0] ACC_HIDDEN = ACC_W'(Y_HIDDEN) << FRAC_BITS;
  localparam logic [ACC_W-1:0] ACC_PEAK   = ACC_W'(Y_PEAK) << FRAC_BITS;
  localparam logic [EXT_W-1:0] UP_EXT     = EXT_W'(UP_STEP);
  localparam logic [EXT_W-1:0] DN_EXT     = EXT_W'(DOWN_STEP);
  localparam logic [POS_W-1:0] PEAK_INT   = POS_W'(Y_PEAK);
  localparam logic [INT_W-1:0] HIDDEN_INT = INT_W'(Y_HIDDEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] xpos_q, xpos_d;
  logic [POS_W-1:0] ypos_q;
  logic             busy_q;
  logic             done_q, done_d;

  logic [EXT_W-1:0] rise_ext;
  logic [EXT_W-1:0] fall_ext;
  logic             rise_clamp;
  logic             fall_land;

  // One extra bit catches borrow on the way up and carry on the way down.
  assign rise_ext   = {1'b0, acc_q} - UP_EXT;
  assign fall_ext   = {1'b0, acc_q} + DN_EXT;
  assign rise_clamp = rise_ext[EXT_W-1] || (rise_ext[ACC_W-1:FRAC_BITS] <= PEAK_INT);
  assign fall_land  = (fall_ext[EXT_W-1:FRAC_BITS] >= HIDDEN_INT);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xpos_d  = xpos_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RISE;
          xpos_d  = bus.duck_xpos;
        end
      end
      RISE: begin
        if (bus.abort) begin
          state_d = FALL;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (rise_clamp) begin
            acc_d   = ACC_PEAK;
            cnt_d   = CNT_LOAD;
            state_d = HOLD;
          end else begin
            acc_d = rise_ext[ACC_W-1:0];
          end
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_d = FALL;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = FALL;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      FALL: begin
        if (bus.tick) begin
          if (fall_land) begin
            acc_d   = ACC_HIDDEN;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            acc_d = fall_ext[ACC_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPRITE_XTRACK_EN
    if (state_q != IDLE) xpos_d = bus.duck_xpos;
`endif
  end

  // State and registered outputs; ypos and busy are derived from the next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= ACC_HIDDEN;
      cnt_q   <= '0;
      xpos_q  <= POS_W'(X_DEFAULT);
      ypos_q  <= POS_W'(Y_HIDDEN);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xpos_q  <= xpos_d;
      ypos_q  <= acc_d[ACC_W-1:FRAC_BITS];
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign bus.xpos = xpos_q;
  assign bus.ypos = ypos_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sprite_popup_ctl.sv
// Scoreboard bench for sprite_popup_ctl: expected output-change events are queued by
// the stimulus process and popped by per-instance monitors on every output change.
`timescale 1ns/1ps
module tb_sprite_popup_ctl;

`ifdef SPRITE_XTRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef struct {
    logic [11:0] y;
    logic        busy;
    logic        done;
    logic [11:0] x;
    int          gap;   // cycles since previous event, 0 = not checked
  } evt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  evt_t qa[$];
  evt_t qb[$];

  sprite_popup_ctl_if ifa ();
  sprite_popup_ctl_if ifb ();

  sprite_popup_ctl #(.FRAC_BITS(4), .Y_HIDDEN(700), .Y_PEAK(480), .UP_STEP(160),
                     .DOWN_STEP(320), .HOLD_TICKS(3), .X_DEFAULT(200))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  sprite_popup_ctl #(.FRAC_BITS(4), .Y_HIDDEN(700), .Y_PEAK(480), .UP_STEP(2400),
                     .DOWN_STEP(2400), .HOLD_TICKS(2), .X_DEFAULT(200))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void cmp_evt(input string nm, input evt_t e, input logic [11:0] y,
                                  input logic b, input logic d, input logic [11:0] x,
                                  input int gap);
    n_chk++;
    if (y !== e.y || b !== e.busy || d !== e.done || x !== e.x || (e.gap != 0 && gap != e.gap)) begin
      n_fail++;
      $display("FAIL %s @%0t: got y=%0d busy=%0b done=%0b x=%0d gap=%0d, expected y=%0d busy=%0b done=%0b x=%0d gap=%0d",
               nm, $time, y, b, d, x, gap, e.y, e.busy, e.done, e.x, e.gap);
    end
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor for dut_a
  logic [11:0] pa_y, pa_x;
  logic        pa_b, pa_d;
  int          la_cyc = 0;
  always @(negedge clk) begin
    if ({ifa.ypos, ifa.busy, ifa.done, ifa.xpos} !== {pa_y, pa_b, pa_d, pa_x}) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut_a_unexpected @%0t: y=%0d busy=%0b done=%0b x=%0d with no event expected",
                 $time, ifa.ypos, ifa.busy, ifa.done, ifa.xpos);
      end else begin
        cmp_evt("dut_a_event", qa.pop_front(), ifa.ypos, ifa.busy, ifa.done, ifa.xpos, cyc - la_cyc);
      end
      {pa_y, pa_b, pa_d, pa_x} = {ifa.ypos, ifa.busy, ifa.done, ifa.xpos};
      la_cyc = cyc;
    end
  end

  // Monitor for dut_b
  logic [11:0] pb_y, pb_x;
  logic        pb_b, pb_d;
  int          lb_cyc = 0;
  always @(negedge clk) begin
    if ({ifb.ypos, ifb.busy, ifb.done, ifb.xpos} !== {pb_y, pb_b, pb_d, pb_x}) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut_b_unexpected @%0t: y=%0d busy=%0b done=%0b x=%0d with no event expected",
                 $time, ifb.ypos, ifb.busy, ifb.done, ifb.xpos);
      end else begin
        cmp_evt("dut_b_event", qb.pop_front(), ifb.ypos, ifb.busy, ifb.done, ifb.xpos, cyc - lb_cyc);
      end
      {pb_y, pb_b, pb_d, pb_x} = {ifb.ypos, ifb.busy, ifb.done, ifb.xpos};
      lb_cyc = cyc;
    end
  end

  task automatic push_a(input int y, input bit b, input bit d, input int x, input int gap);
    evt_t e;
    e.y = 12'(y); e.busy = b; e.done = d; e.x = 12'(x); e.gap = gap;
    qa.push_back(e);
  endtask

  task automatic push_b(input int y, input bit b, input bit d, input int x, input int gap);
    evt_t e;
    e.y = 12'(y); e.busy = b; e.done = d; e.x = 12'(x); e.gap = gap;
    qb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.tick = 1'b1; ifa.start = 1'b0; ifa.abort = 1'b0; ifa.duck_xpos = 12'd0;
    ifb.tick = 1'b1; ifb.start = 1'b0; ifb.abort = 1'b0; ifb.duck_xpos = 12'd200;
    push_a(700, 0, 0, 200, 0);
    push_b(700, 0, 0, 200, 0);
    #1 rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(2);

    // Full cycle: 22 rise ticks, 3 hold ticks, 11 fall ticks
    push_a(700, 1, 0, 321, 0);
    for (int k = 1; k <= 22; k++) push_a(700 - 10 * k, 1, 0, 321, 1);
    push_a(500, 1, 0, 321, 4);
    for (int k = 1; k <= 9; k++) push_a(500 + 20 * k, 1, 0, 321, 1);
    push_a(700, 0, 1, 321, 1);
    push_a(700, 0, 0, 321, 1);
    ifa.duck_xpos = 12'd321; ifa.start = 1'b1;
    wait_n(1);
    ifa.start = 1'b0;
    wait_n(40);

    // Abort at y=600 with tick high; abort held into FALL, then pulsed in IDLE
    push_a(700, 1, 0, 50, 0);
    for (int k = 1; k <= 10; k++) push_a(700 - 10 * k, 1, 0, 50, 1);
    push_a(620, 1, 0, 50, 2);
    for (int k = 2; k <= 4; k++) push_a(600 + 20 * k, 1, 0, 50, 1);
    push_a(700, 0, 1, 50, 1);
    push_a(700, 0, 0, 50, 1);
    ifa.duck_xpos = 12'd50; ifa.start = 1'b1;
    wait_n(1);
    ifa.start = 1'b0;
    wait_n(10);
    ifa.abort = 1'b1;
    wait_n(4);
    ifa.abort = 1'b0;
    wait_n(10);
    ifa.abort = 1'b1;
    wait_n(2);
    ifa.abort = 1'b0;
    wait_n(3);

    // Tick every 4th cycle; extra starts while busy must be ignored
    push_a(700, 1, 0, 77, 0);
    push_a(690, 1, 0, 77, 3);
    for (int k = 2; k <= 22; k++) push_a(700 - 10 * k, 1, 0, 77, 4);
    push_a(500, 1, 0, 77, 16);
    for (int k = 1; k <= 9; k++) push_a(500 + 20 * k, 1, 0, 77, 4);
    push_a(700, 0, 1, 77, 4);
    push_a(700, 0, 0, 77, 1);
    ifa.duck_xpos = 12'd77;
    for (int i = 0; i < 160; i++) begin
      ifa.tick  = (i % 4 == 3);
      ifa.start = (i == 0 || i == 20 || i == 90);
      wait_n(1);
    end
    ifa.tick = 1'b1; ifa.start = 1'b0;
    wait_n(3);

    // X ramp during RISE; start together with abort in IDLE (start wins)
    push_a(700, 1, 0, 100, 0);
    for (int k = 1; k <= 22; k++)
      push_a(700 - 10 * k, 1, 0, TRACK ? 100 + 10 * ((k < 4) ? k : 4) : 100, 1);
    push_a(500, 1, 0, TRACK ? 140 : 100, 4);
    for (int k = 1; k <= 9; k++) push_a(500 + 20 * k, 1, 0, TRACK ? 140 : 100, 1);
    push_a(700, 0, 1, TRACK ? 140 : 100, 1);
    push_a(700, 0, 0, TRACK ? 140 : 100, 1);
    ifa.duck_xpos = 12'd100; ifa.start = 1'b1; ifa.abort = 1'b1;
    wait_n(1);
    ifa.start = 1'b0; ifa.abort = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ifa.duck_xpos = 12'(100 + 10 * k);
      wait_n(1);
    end
    wait_n(40);

    // Clamp at both ends on dut_b: 700 -> 550 -> 480, 480 -> 630 -> 700
    push_b(700, 1, 0, 200, 0);
    push_b(550, 1, 0, 200, 1);
    push_b(480, 1, 0, 200, 1);
    push_b(630, 1, 0, 200, 3);
    push_b(700, 0, 1, 200, 1);
    push_b(700, 0, 0, 200, 1);
    ifb.start = 1'b1;
    wait_n(1);
    ifb.start = 1'b0;
    wait_n(12);

    // Asynchronous reset mid-RISE at y=600
    push_a(700, 1, 0, 555, 0);
    for (int k = 1; k <= 10; k++) push_a(700 - 10 * k, 1, 0, 555, 1);
    push_a(700, 0, 0, 200, 0);
    ifa.duck_xpos = 12'd555; ifa.start = 1'b1;
    wait_n(1);
    ifa.start = 1'b0;
    wait_n(10);
    chk("pre_reset_ypos", int'(ifa.ypos), 600);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ypos", int'(ifa.ypos), 700);
    chk("reset_xpos", int'(ifa.xpos), 200);
    chk("reset_busy", int'(ifa.busy), 0);
    chk("reset_done", int'(ifa.done), 0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(5);

    chk("dut_a_queue_left", qa.size(), 0);
    chk("dut_b_queue_left", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
